systolic_seq_ctrl: RTL and testbench

//  Sequencer for the KxK weight-stationary systolic array (processing_element grid).
//  - Accepts a host start request and, when needed, drives the weight-load phase.
//  - Generates skewed per-row data-feed valids and row indices, then waits for the array to drain.
//  - Pulses result capture and done.

---
 rtl/systolic_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a KxK weight-stationary systolic array: weight load, skewed row feed,
// drain, result capture and run completion. All outputs are registered.
module systolic_seq_ctrl #(
  parameter int unsigned K         = 2,
  parameter int unsigned DRAIN_CYC = 2,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned RUN_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 wt_reload,
  input  logic                 abort,
  output logic                 busy,
  output logic                 load_weights,
  output logic [CNT_W-1:0]     w_row_idx,
  output logic [K-1:0]         feed_valid,
  output logic [K*CNT_W-1:0]   feed_idx,
  output logic                 capture,
  output logic                 done,
  output logic                 wt_loaded,
  output logic [RUN_W-1:0]     runs_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_W = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] LAST_F = CNT_W'(2 * K - 2);
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DRAIN_CYC - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               wt_loaded_nx;

  logic               load_weights_d;
  logic [CNT_W-1:0]   w_row_idx_d;
  logic [K-1:0]       feed_valid_d;
  logic [K*CNT_W-1:0] feed_idx_d;
  logic               capture_d;
  logic               done_d;

  // Next state; cnt is the step counter within the current phase.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    wt_loaded_nx = wt_loaded;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx = (wt_reload || !wt_loaded) ? S_LOAD_W : S_FEED;
          cnt_nx   = '0;
        end
      end
      S_LOAD_W: begin
        if (cnt == LAST_W) begin
          state_nx     = S_FEED;
          cnt_nx       = '0;
          wt_loaded_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_FEED: begin
        if (cnt == LAST_F) begin
          state_nx = S_DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == LAST_D) begin
          state_nx = S_DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
    // Abort overrides any phase progress; weights half-loaded are not trusted.
    if (abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      if (state == S_LOAD_W) wt_loaded_nx = 1'b0;
    end
  end

  // Output decode from the upcoming state so registered outputs align with it.
  always_comb begin
    load_weights_d = (state_nx == S_LOAD_W);
    w_row_idx_d    = load_weights_d ? cnt_nx : '0;
    feed_valid_d   = '0;
    feed_idx_d     = '0;
    for (int r = 0; r < K; r++) begin
      if ((state_nx == S_FEED) && (cnt_nx >= CNT_W'(r)) && (cnt_nx < CNT_W'(r + K))) begin
        feed_valid_d[r]                 = 1'b1;
        feed_idx_d[r*CNT_W +: CNT_W]    = cnt_nx - CNT_W'(r);
      end
    end
    capture_d = (state_nx == S_DRAIN) && (cnt_nx == LAST_D);
    done_d    = (state_nx == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      busy         <= 1'b0;
      load_weights <= 1'b0;
      w_row_idx    <= '0;
      feed_valid   <= '0;
      feed_idx     <= '0;
      capture      <= 1'b0;
      done         <= 1'b0;
      wt_loaded    <= 1'b0;
      runs_done    <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      busy         <= (state_nx != S_IDLE);
      load_weights <= load_weights_d;
      w_row_idx    <= w_row_idx_d;
      feed_valid   <= feed_valid_d;
      feed_idx     <= feed_idx_d;
      capture      <= capture_d;
      done         <= done_d;
      wt_loaded    <= wt_loaded_nx;
      if (done_d) runs_done <= runs_done + RUN_W'(1);
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: directed runs push expected output beats,
// a monitor pops one whenever the sequencer drives any strobe or valid.
module tb_systolic_seq_ctrl;

  localparam int unsigned K     = 2;
  localparam int unsigned D     = 2;
  localparam int unsigned CW    = 4;
  localparam int unsigned RUN_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              wt_reload = 1'b0;
  logic              abort = 1'b0;
  logic              busy;
  logic              load_weights;
  logic [CW-1:0]     w_row_idx;
  logic [K-1:0]      feed_valid;
  logic [K*CW-1:0]   feed_idx;
  logic              capture;
  logic              done;
  logic              wt_loaded;
  logic [RUN_W-1:0]  runs_done;

  systolic_seq_ctrl #(.K(K), .DRAIN_CYC(D), .CNT_W(CW), .RUN_W(RUN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .wt_reload(wt_reload), .abort(abort),
    .busy(busy), .load_weights(load_weights), .w_row_idx(w_row_idx),
    .feed_valid(feed_valid), .feed_idx(feed_idx), .capture(capture), .done(done),
    .wt_loaded(wt_loaded), .runs_done(runs_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    bit            lw;
    bit [CW-1:0]   wri;
    bit [K-1:0]    fv;
    bit [K*CW-1:0] fi;
    bit            cap;
    bit            dn;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input bit lw, input int wri, input bit [K-1:0] fv,
                      input bit [K*CW-1:0] fi, input bit cap, input bit dn);
    beat_t b;
    b.cyc = c; b.lw = lw; b.wri = CW'(wri); b.fv = fv; b.fi = fi; b.cap = cap; b.dn = dn;
    exp_q.push_back(b);
  endtask

  // Expected beats of one full run starting (start high) in cycle c0.
  task automatic push_run(input int c0, input bit ld);
    int k = 1;
    bit [K-1:0]    fv;
    bit [K*CW-1:0] fi;
    if (ld) begin
      for (int i = 0; i < K; i++) begin
        push(c0 + k, 1'b1, i, '0, '0, 1'b0, 1'b0);
        k++;
      end
    end
    for (int t = 0; t < 2 * K - 1; t++) begin
      fv = '0; fi = '0;
      for (int r = 0; r < K; r++) begin
        if (t >= r && t < r + K) begin
          fv[r] = 1'b1;
          fi[r*CW +: CW] = CW'(t - r);
        end
      end
      push(c0 + k, 1'b0, 0, fv, fi, 1'b0, 1'b0);
      k++;
    end
    k += D - 1;
    push(c0 + k, 1'b0, 0, '0, '0, 1'b1, 1'b0);
    k++;
    push(c0 + k, 1'b0, 0, '0, '0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle with any active output consumes one expected beat.
  always @(negedge clk) begin
    if (!rst && (load_weights || feed_valid != '0 || capture || done)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output @cyc %0d: lw=%b wri=%0d fv=%b fi=%h cap=%b done=%b required none",
                 cyc, load_weights, w_row_idx, feed_valid, feed_idx, capture, done);
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        if (cyc != e.cyc || load_weights != e.lw || w_row_idx != e.wri || feed_valid != e.fv ||
            feed_idx != e.fi || capture != e.cap || done != e.dn) begin
          n_err++;
          $display("FAIL beat: got cyc=%0d lw=%b wri=%0d fv=%b fi=%h cap=%b done=%b required cyc=%0d lw=%b wri=%0d fv=%b fi=%h cap=%b done=%b",
                   cyc, load_weights, w_row_idx, feed_valid, feed_idx, capture, done,
                   e.cyc, e.lw, e.wri, e.fv, e.fi, e.cap, e.dn);
        end
      end
    end
  end

  task automatic run(input bit reload, input bit exp_ld, input int exp_lat, input int exp_runs,
                     input int pulse_at);
    int c0;
    int lat = -1;
    @(negedge clk);
    c0 = cyc;
    push_run(c0, exp_ld);
    start = 1'b1;
    wt_reload = reload;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      wt_reload = 1'b0;
      if (done) lat = cyc - c0;
    end
    start = 1'b0;
    chk("done_latency", lat, exp_lat);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("runs_done", runs_done, exp_runs);
    chk("wt_loaded", wt_loaded, 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {busy, load_weights, w_row_idx, feed_valid, feed_idx, capture, done, wt_loaded,
               runs_done}, 0);
  endtask

  initial begin
    int c0;
    #12;
    chk_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    // Full run with weight load, then one reusing the loaded weights.
    run(1'b1, 1'b1, 8, 1, 0);
    run(1'b0, 1'b0, 6, 2, 0);

    // Abort in the second LOAD_W cycle.
    @(negedge clk);
    c0 = cyc;
    push(c0 + 1, 1'b1, 0, '0, '0, 1'b0, 1'b0);
    push(c0 + 2, 1'b1, 1, '0, '0, 1'b0, 1'b0);
    start = 1'b1; wt_reload = 1'b1;
    @(negedge clk);
    start = 1'b0; wt_reload = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_load_weights", load_weights, 0);
    chk("abort_wt_loaded", wt_loaded, 0);
    chk("abort_runs_done", runs_done, 2);
    repeat (12) @(negedge clk);
    chk("abort_pending_beats", exp_q.size(), 0);

    // Weights invalid after abort: load is forced even without reload.
    run(1'b0, 1'b1, 8, 3, 0);
    // Start pulsed during FEED is dropped.
    run(1'b0, 1'b0, 6, 4, 2);
    repeat (10) @(negedge clk);
    chk("no_queued_start", runs_done, 4);

    // Start together with abort in IDLE does nothing.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    repeat (10) @(negedge clk);
    chk("start_abort_still_idle", busy, 0);

    // Asynchronous reset in the middle of FEED.
    @(negedge clk);
    c0 = cyc;
    push_run(c0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("feed_active_before_rst", feed_valid, 2'b11);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_rst_mid_feed");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 1'b1, 8, 1, 0);

    repeat (5) @(negedge clk);
    chk("final_pending_beats", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
